// File: rtl/plic_pkg.sv
// Package for the minimal platform-level interrupt controller.
// Holds the shared widths, the register-map byte offsets and a small
// address-decode helper used by the top level.
package plic_pkg;

    localparam int PRIO_W  = 3;   // source priority / context threshold width
    localparam int NUM_SRC = 2;   // source IDs 0..1, ID 0 reserved
    localparam int ID_W    = 10;  // width of claim/complete IDs

    localparam logic [25:0] PRIORITY_BASE  = 26'h000_0000;
    localparam logic [25:0] PENDING_BASE   = 26'h000_1000;
    localparam logic [25:0] ENABLE_BASE    = 26'h000_2000;
    localparam logic [25:0] CTX0_THRESHOLD = 26'h020_0000;
    localparam logic [25:0] CTX0_CLAIM     = 26'h020_0004;

    // Word-granular address match: byte-lane bits [1:0] are ignored.
    function automatic logic addr_hit(input logic [25:0] addr, input logic [25:0] base);
        return (addr[25:2] == base[25:2]);
    endfunction

endpackage

// File: rtl/plic_gateway.sv
// Interrupt gateway for one source.
// Latches a request (level or single-cycle pulse) into pending, moves it to
// in_service on claim and releases it on complete. New requests are dropped
// while the source is pending or in service.
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   irq            raw source request
//   claim          the context claimed this source this cycle
//   complete       the context completed this source this cycle
//   pending        request latched, awaiting claim
//   in_service     request claimed, awaiting completion
module plic_gateway (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    logic pending_r;
    logic in_service_r;
    logic pending_nxt_s;
    logic in_service_nxt_s;

    // Next-state for pending/in_service. A complete edge never latches a new
    // request; a still-high irq gets picked up on the following edge.
    always_comb begin
        pending_nxt_s    = pending_r;
        in_service_nxt_s = in_service_r;
        if (claim) begin
            pending_nxt_s    = 1'b0;
            in_service_nxt_s = 1'b1;
        end else if (complete) begin
            in_service_nxt_s = 1'b0;
        end else if (irq && !pending_r && !in_service_r) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s    = pending_r;
            in_service_nxt_s = in_service_r;
        end
    end

    // Gateway state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r    <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            pending_r    <= pending_nxt_s;
            in_service_r <= in_service_nxt_s;
        end
    end

    assign pending    = pending_r;
    assign in_service = in_service_r;

endmodule

// File: rtl/platform_level_interrupt_ctrl.sv
// Minimal PLIC: one hart context, sources 0 (reserved) and 1.
// Word-addressed bus slave with single-cycle cs/we accesses and registered
// read data; source 1 passes through a gateway and is arbitrated against the
// context threshold to drive the external interrupt pending line.
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   cs, we, addr      bus access strobe, write flag, byte address
//   wr_data           write data
//   rd_data           registered read data (1-cycle latency, holds otherwise)
//   irq__0, irq__1    source requests (ID 0 is ignored)
//   context__0__eip   external interrupt pending to hart context 0
module platform_level_interrupt_ctrl
    import plic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [25:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        irq__0,
    input  logic        irq__1,
    output logic        context__0__eip
);

    logic [PRIO_W-1:0] priority1_r;
    logic [PRIO_W-1:0] threshold_r;
    logic              enable1_r;
    logic [31:0]       rd_data_r;

    logic              pending1_s;
    logic              in_service1_s;
    logic              eligible1_s;
    logic [ID_W-1:0]   claim_id_s;
    logic              rd_s;
    logic              wr_s;
    logic              claim_s;
    logic              complete_s;
    logic [31:0]       rd_mux_s;
    logic              unused_s;

    assign unused_s = ^{irq__0, addr[1:0], wr_data[31:ID_W]};

    assign rd_s = cs && !we;
    assign wr_s = cs && we;

    assign eligible1_s = pending1_s && enable1_r && (priority1_r > threshold_r);
    assign claim_id_s  = eligible1_s ? 10'd1 : 10'd0;

    // A claim only takes effect when it actually returns a nonzero ID.
    assign claim_s    = rd_s && addr_hit(addr, CTX0_CLAIM) && eligible1_s;
    // Completion matches against the in-service ID only, independent of enable.
    assign complete_s = wr_s && addr_hit(addr, CTX0_CLAIM) &&
                        (wr_data[ID_W-1:0] == 10'd1) && in_service1_s;

    plic_gateway u_gateway1 (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq__1),
        .claim      (claim_s),
        .complete   (complete_s),
        .pending    (pending1_s),
        .in_service (in_service1_s)
    );

    // Read-data multiplexer over the register map; unmapped locations read 0.
    always_comb begin
        rd_mux_s = 32'd0;
        if (addr_hit(addr, PRIORITY_BASE + 26'd4)) begin
            rd_mux_s = {{(32-PRIO_W){1'b0}}, priority1_r};
        end else if (addr_hit(addr, PENDING_BASE)) begin
            rd_mux_s = {30'd0, pending1_s, 1'b0};
        end else if (addr_hit(addr, ENABLE_BASE)) begin
            rd_mux_s = {30'd0, enable1_r, 1'b0};
        end else if (addr_hit(addr, CTX0_THRESHOLD)) begin
            rd_mux_s = {{(32-PRIO_W){1'b0}}, threshold_r};
        end else if (addr_hit(addr, CTX0_CLAIM)) begin
            rd_mux_s = {{(32-ID_W){1'b0}}, claim_id_s};
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Configuration registers and registered read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            priority1_r <= {{(PRIO_W-1){1'b0}}, 1'b1};
            threshold_r <= {PRIO_W{1'b0}};
            enable1_r   <= 1'b0;
            rd_data_r   <= 32'd0;
        end else begin
            if (wr_s) begin
                if (addr_hit(addr, PRIORITY_BASE + 26'd4)) begin
                    priority1_r <= wr_data[PRIO_W-1:0];
                end else if (addr_hit(addr, ENABLE_BASE)) begin
                    enable1_r <= wr_data[1];
                end else if (addr_hit(addr, CTX0_THRESHOLD)) begin
                    threshold_r <= wr_data[PRIO_W-1:0];
                end else begin
                    priority1_r <= priority1_r;
                end
            end
            if (rd_s) begin
                rd_data_r <= rd_mux_s;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign rd_data         = rd_data_r;
    assign context__0__eip = eligible1_s;

endmodule

// File: tb/tb_platform_level_interrupt_ctrl.sv
// Directed bench for platform_level_interrupt_ctrl. Each read pushes the
// expected rd_data and the expected eip level (as seen after the read edge)
// into a scoreboard queue; a monitor pops and compares one entry per read.
module tb_platform_level_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [25:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq__0;
    logic        irq__1;
    logic        context__0__eip;

    typedef struct {
        logic [31:0] rd;
        logic        eip;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_issue_r = 1'b0;
    logic done = 1'b0;

    localparam logic [25:0] A_PRIO0 = 26'h000_0000;
    localparam logic [25:0] A_PRIO1 = 26'h000_0004;
    localparam logic [25:0] A_PEND  = 26'h000_1000;
    localparam logic [25:0] A_EN    = 26'h000_2000;
    localparam logic [25:0] A_UNMAP = 26'h000_3000;
    localparam logic [25:0] A_THR   = 26'h020_0000;
    localparam logic [25:0] A_CLAIM = 26'h020_0004;

    platform_level_interrupt_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cs              (cs),
        .we              (we),
        .addr            (addr),
        .wr_data         (wr_data),
        .rd_data         (rd_data),
        .irq__0          (irq__0),
        .irq__1          (irq__1),
        .context__0__eip (context__0__eip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_issue_r <= cs && !we;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [25:0] a, input logic [31:0] e, input logic eip, input string n);
        exp_t x;
        x.rd = e; x.eip = eip; x.name = n;
        exp_q.push_back(x);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        cs = 1'b0;
    endtask

    task automatic wr(input logic [25:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic pulse1();
        irq__1 = 1'b1;
        tick();
        irq__1 = 1'b0;
    endtask

    // Monitor: compare one scoreboard entry per completed read, then report.
    initial begin
        int cyc = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_issue_r) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read actual rd_data=%0h with empty scoreboard", rd_data);
                end else begin
                    x = exp_q.pop_front();
                    checks++;
                    if (rd_data !== x.rd) begin
                        errors++;
                        $display("FAIL %s rd_data actual=%0h required=%0h", x.name, rd_data, x.rd);
                    end
                    checks++;
                    if (context__0__eip !== x.eip) begin
                        errors++;
                        $display("FAIL %s eip actual=%0b required=%0b", x.name, context__0__eip, x.eip);
                    end
                end
            end
            if ((done && exp_q.size() == 0) || cyc > 5000) begin
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL timeout outstanding actual=%0d required=0", exp_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin
        rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 26'd0; wr_data = 32'd0;
        irq__0 = 1'b0; irq__1 = 1'b0;
        tick();
        rd(A_PRIO1, 32'd0, 1'b0, "read_in_reset");
        rst = 1'b1;

        rd(A_PRIO1, 32'd1, 1'b0, "rst_prio1");
        rd(A_EN,    32'd0, 1'b0, "rst_enable");
        rd(A_THR,   32'd0, 1'b0, "rst_threshold");
        rd(A_PEND,  32'd0, 1'b0, "rst_pending");
        rd(A_PRIO0, 32'd0, 1'b0, "prio0_zero");

        // Basic request / claim.
        wr(A_EN, 32'h2);
        pulse1();
        rd(A_PEND,  32'h2, 1'b1, "pend_after_pulse");
        rd(A_EN,    32'h2, 1'b1, "enable_set");
        rd(A_CLAIM, 32'd1, 1'b0, "claim_id1");
        rd(A_CLAIM, 32'd0, 1'b0, "claim_again_zero");

        // Requests dropped while in service; complete with irq held high.
        pulse1();
        rd(A_PEND, 32'h0, 1'b0, "drop_in_service");
        irq__1 = 1'b1;
        wr(A_CLAIM, 32'd1);
        rd(A_PEND, 32'h0, 1'b1, "no_latch_on_complete");
        irq__1 = 1'b0;
        rd(A_PEND, 32'h2, 1'b1, "relatch_after_complete");

        // Threshold and priority.
        wr(A_THR, 32'd1);
        rd(A_CLAIM, 32'd0, 1'b0, "claim_blocked_thr");
        rd(A_PEND,  32'h2, 1'b0, "pend_kept_thr");
        rd(A_THR,   32'd1, 1'b0, "thr_readback");
        wr(A_PRIO1, 32'd2);
        rd(A_PRIO1, 32'd2, 1'b1, "prio_raised");
        wr(A_PRIO1, 32'hF);
        rd(A_PRIO1, 32'd7, 1'b1, "prio_width");
        wr(A_PRIO1, 32'd2);
        rd(A_CLAIM, 32'd1, 1'b0, "claim_prio2");
        wr(A_CLAIM, 32'd0);
        wr(A_CLAIM, 32'd5);
        pulse1();
        rd(A_PEND, 32'h0, 1'b0, "bad_complete_ignored");
        wr(A_CLAIM, 32'd1);
        wr(A_CLAIM, 32'd1);

        // Claim returning 0 on the same edge irq latches.
        irq__1 = 1'b1;
        rd(A_CLAIM, 32'd0, 1'b1, "claim_zero_same_edge");
        irq__1 = 1'b0;
        rd(A_PEND, 32'h2, 1'b1, "pend_after_same_edge");

        // Enable gating, and completion regardless of enable.
        rd(A_CLAIM, 32'd1, 1'b0, "claim_before_disable");
        wr(A_CLAIM, 32'd1);
        wr(A_EN, 32'h0);
        pulse1();
        rd(A_PEND,  32'h2, 1'b0, "pend_disabled");
        rd(A_CLAIM, 32'd0, 1'b0, "claim_disabled");
        wr(A_EN, 32'hFFFF_FFFF);
        rd(A_EN,    32'h2, 1'b1, "enable_only_bit1");
        rd(A_CLAIM, 32'd1, 1'b0, "claim_reenabled");
        wr(A_EN, 32'h0);
        wr(A_CLAIM, 32'd1);
        wr(A_EN, 32'h2);
        pulse1();
        rd(A_PEND, 32'h2, 1'b1, "complete_while_disabled");

        // Source 0 reserved.
        irq__0 = 1'b1;
        tick();
        irq__0 = 1'b0;
        wr(A_CLAIM, 32'd0);
        wr(A_PRIO0, 32'd7);
        rd(A_PEND,  32'h2, 1'b1, "src0_no_effect");
        rd(A_PRIO0, 32'd0, 1'b1, "prio0_read_only");

        // Reset mid-service.
        rd(A_CLAIM, 32'd1, 1'b0, "claim_before_reset");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd(A_PRIO1, 32'd1, 1'b0, "rst2_prio1");
        rd(A_EN,    32'd0, 1'b0, "rst2_enable");
        rd(A_THR,   32'd0, 1'b0, "rst2_threshold");
        rd(A_PEND,  32'd0, 1'b0, "rst2_pending");
        pulse1();
        rd(A_PEND,  32'h2, 1'b0, "rst2_service_cleared");
        wr(A_UNMAP, 32'h2);
        wr(A_PEND,  32'h0);
        rd(A_UNMAP, 32'd0, 1'b0, "unmapped_read");
        rd(A_PEND,  32'h2, 1'b0, "pending_read_only");
        rd(A_EN,    32'd0, 1'b0, "enable_untouched");

        tick();
        done = 1'b1;
    end

endmodule

// File: doc/platform_level_interrupt_ctrl.md
Name: platform_level_interrupt_ctrl

Overview:
- Minimal RISC-V-style PLIC: one hart context (context 0) and two interrupt inputs; source IDs 0..1, where ID 0 is reserved.
- Sits on the system memory bus as a 26-bit word-addressed slave with a single-cycle cs/we interface.
- Latches source requests in gateways and arbitrates enabled sources against a priority threshold.
- Drives the external-interrupt-pending line to the core, and supports claim/complete through one register.

Parameters:
- PRIO_W, 3, width of the source priority and context threshold registers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- cs  in  1  bus chip select; an access occurs on each edge where cs=1.
- we  in  1  1 = write, 0 = read; valid while cs=1.
- addr  in  26  byte address; bits [1:0] ignored.
- wr_data  in  32  write data.
- rd_data  out  32  registered read data.
- irq__0  in  1  source ID 0; reserved, ignored internally.
- irq__1  in  1  source ID 1 request, level or pulse.
- context__0__eip  out  1  external interrupt pending to hart context 0.

Behaviour:
- Register map (byte offsets). Unmapped reads return 0; writes to unmapped or read-only locations are ignored.
  - 0x000000: priority of source 0; reads 0, read-only.
  - 0x000004: priority of source 1, PRIO_W bits, RW; reset 1.
  - 0x001000: pending bits, read-only; bit1 = source 1 pending, bit0 always 0.
  - 0x002000: context 0 enable bits; bit1 RW, all other bits 0; reset 0.
  - 0x200000: context 0 threshold, PRIO_W bits, RW; reset 0.
  - 0x200004: context 0 claim on read, complete on write.
- Reset (rst=0 at an edge):
  - rd_data=0, pending=0, in_service=0, enable=0, threshold=0, priority1=1.
  - context__0__eip=0 the following cycle.
- Gateway (source 1): at an edge where irq__1=1, pending=0 and in_service=0, set pending. A one-cycle pulse is enough to latch a request. While pending or in service, further requests are dropped.
- Eligibility: source 1 is eligible when pending & enable[1] & (priority1 > threshold).
- context__0__eip is combinational from registered state and equals eligible. It rises the cycle after the edge that set pending.
- Read: at an edge with cs=1, we=0, rd_data loads the addressed value, giving 1-cycle latency. rd_data holds its value when there is no read.
- Claim: a read of 0x200004 returns the highest-priority eligible ID, or 0 if none (only source 1 can be returned). If nonzero, the same edge clears pending and sets in_service.
  - A claim sustained over consecutive cycles returns the ID once, then 0.
- Complete: a write to 0x200004 whose wr_data[9:0] equals an in-service ID clears in_service.
  - Completion is honoured regardless of enable.
  - A write with a non-matching ID, or ID 0, is ignored.
  - A write held for several cycles is harmless.
- Simultaneous events:
  - A claim evaluates pre-edge state. If irq sets pending on the same edge that a claim returns 0, pending remains set.
  - On a complete edge the gateway does not set pending; a still-high irq is re-latched on the next edge.
- Writes occur at an edge with cs=1, we=1.

Decomposition:
- Package plic_pkg holds:
  - PRIO_W, the source count (2), and the ID width (10);
  - address constants PRIORITY_BASE=0x000000, PENDING_BASE=0x001000, ENABLE_BASE=0x002000, CTX0_THRESHOLD=0x200000, CTX0_CLAIM=0x200004.
- One sub-module, plic_gateway, holds the per-source pending/in_service logic, with inputs irq, claim and complete. It is instantiated for source 1.

Test Plan:
- Reset, then read 0x000004, 0x002000, 0x200000 and 0x001000 -> 1, 0, 0, 0; eip=0.
- Write 0x2 to 0x002000; pulse irq__1 for one cycle -> pending reads 0x2 and eip=1 the cycle after the pulse edge. Read 0x200004 -> rd_data=1 next cycle, eip drops, and a continued read returns 0.
- While source 1 is in service, pulse irq__1 again -> no pending and eip stays 0. Write 1 to 0x200004 -> in_service clears, and a new irq__1 pulse sets pending again.
- Write threshold=1 to 0x200000 with priority1=1 and a request pending -> eip=0 and claim returns 0. Write priority1=2 -> eip=1.
- With enable=0, pulse irq__1 -> pending=0x2 but eip=0. Enable it -> eip=1 without a new pulse.
- Pulse irq__0 and write complete ID 0 -> no state change. Assert rst mid-service -> all registers return to reset values.
